digit_glyph_fetch_sched: RTL
============================

// Module: digit_glyph_fetch_sched
// PURPOSE
// Per-pixel scheduler sharing one glyph ROM among the six stat-digit fields of the 640x480 erg display.
// Tracks the raster address and decides which digit field, if any, covers the pixel.
// Issues at most one glyph ROM read per cycle and returns the glyph pixel aligned with a valid strobe.
// Double-buffers digit values from the stats logic; new values take effect only at frame start (no tearing).
// PARAMETERS
// ROM_LAT   1   glyph ROM read latency in cycles (1..2)
// PIX_W     8   glyph ROM data width (colour index)
// ROM_AW    13  glyph ROM address width (10 glyphs x 616 = 6160 words)
// PORTS
// clock       in   1       system clock
// resetn      in   1       asynchronous reset, active-low
// ADDR        in   19      raster pixel address, y*640+x
// addr_valid  in   1       ADDR is valid this cycle
// frame_start in   1       one-cycle pulse at start of vertical blank
// upd_valid   in   1       digit update request
// upd_ready   out  1       update accepted when upd_valid & upd_ready
// upd_field   in   3       0 ratio_ones, 1 rush_ones, 2 rush_tenths, 3 cons_ones, 4 cons_tenths, 5 cons_hundredths
// upd_digit   in   4       0..9 digit, 4'hF blank, 10..14 illegal
// rom_rd      out  1       glyph ROM read enable
// rom_addr    out  ROM_AW  glyph ROM address
// rom_q       in   PIX_W   glyph ROM data, valid ROM_LAT cycles after rom_rd
// out_valid   out  1       glyph_hit/glyph_pix correspond to an input ADDR
// glyph_hit   out  1       pixel lies inside a non-blank digit field
// glyph_pix   out  PIX_W   glyph pixel; 0 when glyph_hit=0
// err_sticky  out  1       illegal update seen; cleared only by reset
// BEHAVIOUR
// - Reset (async assert, sync deassert): all shadow and active digits 4'hF; dirty=0; pipeline valids 0.
//   Also rom_rd=0, rom_addr=0, out_valid=0, glyph_hit=0, glyph_pix=0, err_sticky=0; upd_ready=1 on first clock.
// - Stage S1: on addr_valid, register x=ADDR%640 and y=ADDR/640 (constant divide) plus valid bit.
// - Stage S2: test fields in index order; first match wins. Every field is 22x28 at these origins (x0,y0):
//   (160,29), (160,78), (200,78), (532,29), (568,29), (594,29). Inclusive bounds x0..x0+21, y0..y0+27.
//   On match with active digit d<=9: rom_rd=1, rom_addr=d*616+(y-y0)*22+(x-x0); hit flag is piped along.
//   No match, or d=F: rom_rd=0, hit=0; the valid bit still propagates.
// - Output: out_valid asserts exactly 2+ROM_LAT cycles after addr_valid. With hit: glyph_pix=rom_q; else 0.
//   Pipeline is fully pipelined: one pixel per cycle, no bubbles, no backpressure.
// - Gaps in addr_valid produce matching gaps in out_valid. Non-sequential ADDR is legal (no x/y tracking state).
// - Update FSM, states IDLE, DIRTY, COMMIT:
//   IDLE: accepted legal update writes shadow[field] and moves to DIRTY.
//   DIRTY: further updates overwrite the shadow. frame_start -> COMMIT next cycle.
//   COMMIT (one cycle): active<=shadow for all six fields; upd_ready=0; dirty cleared; next state IDLE.
//   frame_start in IDLE: no commit, stays IDLE.
//   Update and frame_start in the same cycle: the update is written, then included in the following COMMIT.
//   frame_start during COMMIT: ignored.
// - Illegal update (field>=6 or digit 10..14): handshake completes, shadow unchanged, err_sticky<=1, state unchanged.
// - Active digits change only in COMMIT. A pixel in flight keeps the digit sampled at its S2 cycle.
// - resetn asserted mid-frame or mid-COMMIT: all state returns to reset values immediately and pending updates are lost.
// - Widths: offset math in 19 bits, truncated to ROM_AW. Max address 9*616+27*22+21=6159.
// STRUCTURE
// - Package digit_layout_pkg holds SCREEN_W=640, GLYPH_W=22, GLYPH_H=28, GLYPH_SIZE=616, NUM_FIELDS=6.
//   It also holds the field origin table FIELD_X0/FIELD_Y0, the FSM state enum, and DIGIT_BLANK=4'hF.
// - Sub-module digit_field_decode (combinational): x,y in; field_hit, field_idx[2:0], x_off[4:0], y_off[4:0] out. Instantiated in S2.
// - Top level holds the S1/S2/latency pipeline, the shadow/active register banks and the update FSM.
// TESTING
// - Reset, ADDR sweep over a whole frame -> out_valid mirrors addr_valid delayed 3 cycles (ROM_LAT=1); glyph_hit never 1, since all fields are blank.
// - Update field0=7, then frame_start; ADDR=29*640+160 -> rom_addr=4312, glyph_hit=1. ADDR=56*640+181 -> rom_addr=4927. ADDR=29*640+182 -> glyph_hit=0.
// - Update field3=2 with no frame_start -> field3 pixels stay blank. Pulse frame_start -> upd_ready=0 for exactly one cycle, then ADDR=29*640+532 gives rom_addr=1232.
// - upd_valid field5=4 in the same cycle as frame_start -> the value is committed by that frame. A second update one cycle later waits for the next frame_start.
// - Update field=6 or digit=11 -> err_sticky=1, handshake completes, displayed digits unchanged.
// - Assert resetn mid-stream with a dirty shadow -> outputs 0 asynchronously; after release all fields are blank and the FSM is IDLE.

Source files
------------

// File: rtl/digit_glyph_fetch_sched_pkg.sv
// ---------------------------------------------------------------------------
// digit_layout_pkg
// Shared layout constants for the erg display digit overlay: screen width,
// glyph geometry, the six digit-field origins, the update FSM state encoding
// and a helper that forms a glyph ROM word offset.
// No ports (package).
// ---------------------------------------------------------------------------
package digit_layout_pkg;

  localparam int SCREEN_W   = 640;
  localparam int GLYPH_W    = 22;
  localparam int GLYPH_H    = 28;
  localparam int GLYPH_SIZE = 616;
  localparam int NUM_FIELDS = 6;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Field order is also match priority: a lower index wins.
  localparam int FIELD_X0 [NUM_FIELDS] = '{160, 160, 200, 532, 568, 594};
  localparam int FIELD_Y0 [NUM_FIELDS] = '{ 29,  78,  78,  29,  29,  29};

  typedef enum logic [1:0] {
    UPD_IDLE   = 2'd0,
    UPD_DIRTY  = 2'd1,
    UPD_COMMIT = 2'd2
  } upd_state_e;

  // Word offset of a glyph pixel, formed in 19 bits; the caller truncates
  // to the ROM address width.
  function automatic logic [18:0] glyph_offset(input logic [3:0] digit,
                                               input logic [4:0] y_off,
                                               input logic [4:0] x_off);
    return 19'(digit) * 19'(GLYPH_SIZE) + 19'(y_off) * 19'(GLYPH_W) + 19'(x_off);
  endfunction

  // 0..9 and blank are legal digit codes; 10..14 are not.
  function automatic logic digit_legal(input logic [3:0] digit);
    return (digit <= 4'd9) || (digit == DIGIT_BLANK);
  endfunction

endpackage

// File: rtl/digit_glyph_fetch_sched_if.sv
// ---------------------------------------------------------------------------
// digit_glyph_fetch_sched_if
// Bundles the raster, digit-update, glyph ROM and pixel-output signals of
// the glyph fetch scheduler.
//   master : the surrounding system (raster source, stats logic, glyph ROM,
//            pixel consumer)
//   slave  : the scheduler itself
// Signals: ADDR/addr_valid/frame_start (raster), upd_* (digit update
// handshake), rom_rd/rom_addr/rom_q (glyph ROM), out_valid/glyph_hit/
// glyph_pix (pixel out), err_sticky (illegal update flag).
// ---------------------------------------------------------------------------
interface digit_glyph_fetch_sched_if #(
  parameter int PIX_W  = 8,
  parameter int ROM_AW = 13
) ();

  logic [18:0]       ADDR;
  logic              addr_valid;
  logic              frame_start;

  logic              upd_valid;
  logic              upd_ready;
  logic [2:0]        upd_field;
  logic [3:0]        upd_digit;

  logic              rom_rd;
  logic [ROM_AW-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_q;

  logic              out_valid;
  logic              glyph_hit;
  logic [PIX_W-1:0]  glyph_pix;
  logic              err_sticky;

  modport master (
    output ADDR, addr_valid, frame_start,
    output upd_valid, upd_field, upd_digit,
    output rom_q,
    input  upd_ready, rom_rd, rom_addr,
    input  out_valid, glyph_hit, glyph_pix, err_sticky
  );

  modport slave (
    input  ADDR, addr_valid, frame_start,
    input  upd_valid, upd_field, upd_digit,
    input  rom_q,
    output upd_ready, rom_rd, rom_addr,
    output out_valid, glyph_hit, glyph_pix, err_sticky
  );

endinterface

// File: rtl/digit_glyph_fetch_sched_field_decode.sv
// ---------------------------------------------------------------------------
// digit_field_decode
// Combinational test of a screen coordinate against the six digit fields.
//   x_i, y_i      : pixel column / row
//   field_hit_o   : coordinate lies inside some field
//   field_idx_o   : index of the first matching field
//   x_off_o/y_off_o : offset of the pixel inside that field's glyph box
// ---------------------------------------------------------------------------
module digit_field_decode
  import digit_layout_pkg::*;
(
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       field_hit_o,
  output logic [2:0] field_idx_o,
  output logic [4:0] x_off_o,
  output logic [4:0] y_off_o
);

  // Scanned from the highest index down so the lowest matching index is the
  // one left standing.
  always_comb begin
    field_hit_o = 1'b0;
    field_idx_o = '0;
    x_off_o     = '0;
    y_off_o     = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if ((x_i >= 10'(FIELD_X0[i])) && (x_i <= 10'(FIELD_X0[i] + GLYPH_W - 1)) &&
          (y_i >= 10'(FIELD_Y0[i])) && (y_i <= 10'(FIELD_Y0[i] + GLYPH_H - 1))) begin
        field_hit_o = 1'b1;
        field_idx_o = 3'(i);
        x_off_o     = 5'(x_i - 10'(FIELD_X0[i]));
        y_off_o     = 5'(y_i - 10'(FIELD_Y0[i]));
      end
    end
  end

endmodule

// File: rtl/digit_glyph_fetch_sched.sv
// ---------------------------------------------------------------------------
// digit_glyph_fetch_sched
// Per-pixel scheduler sharing one glyph ROM among the six stat-digit fields.
// Pipeline: S1 splits ADDR into x/y, S2 decodes the field and issues the ROM
// read, then ROM_LAT cycles later the glyph pixel is presented with out_valid.
// Digit updates land in a shadow bank and are copied to the active bank only
// in the COMMIT state that follows a frame_start.
// Ports:
//   clock  : system clock
//   resetn : asynchronous reset, active low
//   bus    : digit_glyph_fetch_sched_if.slave (raster, update, ROM, output)
//
// Update FSM
//   state  | meaning
//   IDLE   | shadow equals active, nothing pending
//   DIRTY  | shadow holds at least one new digit awaiting frame_start
//   COMMIT | copying shadow to active; updates held off for this cycle
// ---------------------------------------------------------------------------
module digit_glyph_fetch_sched
  import digit_layout_pkg::*;
#(
  parameter int ROM_LAT = 1,
  parameter int PIX_W   = 8,
  parameter int ROM_AW  = 13
) (
  input  logic                     clock,
  input  logic                     resetn,
  digit_glyph_fetch_sched_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'(UPD_IDLE);
  localparam logic [1:0] ST_DIRTY  = 2'(UPD_DIRTY);
  localparam logic [1:0] ST_COMMIT = 2'(UPD_COMMIT);

  // Digit banks
  logic [3:0] shadow_q [NUM_FIELDS];
  logic [3:0] active_q [NUM_FIELDS];

  // Update FSM
  logic [1:0] state_q, state_d;
  logic       err_q, err_d;
  logic       upd_ready;
  logic       upd_fire;
  logic       upd_legal;
  logic       shadow_wr;

  assign upd_ready = (state_q != ST_COMMIT);
  assign upd_fire  = bus.upd_valid && upd_ready;
  assign upd_legal = (bus.upd_field < 3'(NUM_FIELDS)) && digit_legal(bus.upd_digit);

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    shadow_wr = 1'b0;
    if (upd_fire) begin
      if (upd_legal) shadow_wr = 1'b1;
      else           err_d     = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        // A legal update arriving with frame_start joins this frame's commit.
        if (shadow_wr) state_d = bus.frame_start ? ST_COMMIT : ST_DIRTY;
      end
      ST_DIRTY: begin
        if (bus.frame_start) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        shadow_q[i] <= DIGIT_BLANK;
        active_q[i] <= DIGIT_BLANK;
      end
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        if (shadow_wr && (bus.upd_field == 3'(i))) shadow_q[i] <= bus.upd_digit;
        if (state_q == ST_COMMIT)                  active_q[i] <= shadow_q[i];
      end
    end
  end

  // S1: raster address to x/y
  logic       s1_vld_q;
  logic [9:0] x_q, y_q, x_d, y_d;

  // y is kept 10 bits wide so out-of-frame addresses cannot alias onto a field.
  assign x_d = 10'(bus.ADDR % 19'(SCREEN_W));
  assign y_d = 10'(bus.ADDR / 19'(SCREEN_W));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_vld_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      s1_vld_q <= bus.addr_valid;
      if (bus.addr_valid) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end

  // S2: field decode and ROM read issue
  logic              fld_hit;
  logic [2:0]        fld_idx;
  logic [4:0]        x_off, y_off;
  logic [3:0]        fld_digit;
  logic              s2_hit_d;
  logic [ROM_AW-1:0] rom_addr_d;
  logic              s2_vld_q;
  logic              rom_rd_q;
  logic [ROM_AW-1:0] rom_addr_q;

  digit_field_decode u_decode (
    .x_i         (x_q),
    .y_i         (y_q),
    .field_hit_o (fld_hit),
    .field_idx_o (fld_idx),
    .x_off_o     (x_off),
    .y_off_o     (y_off)
  );

  always_comb begin
    fld_digit = DIGIT_BLANK;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (fld_idx == 3'(i)) fld_digit = active_q[i];
    end
  end

  assign s2_hit_d   = s1_vld_q && fld_hit && (fld_digit != DIGIT_BLANK);
  assign rom_addr_d = s2_hit_d ? ROM_AW'(glyph_offset(fld_digit, y_off, x_off)) : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2_vld_q   <= 1'b0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      s2_vld_q   <= s1_vld_q;
      rom_rd_q   <= s2_hit_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // ROM latency alignment: valid/hit ride a ROM_LAT-deep shift register so
  // they line up with rom_q. Index 0 of the *_sr vectors is the S2 value.
  logic [ROM_LAT:0]   vld_sr, hit_sr;
  logic [ROM_LAT-1:0] vld_pipe_q, hit_pipe_q;

  assign vld_sr = {vld_pipe_q, s2_vld_q};
  assign hit_sr = {hit_pipe_q, rom_rd_q};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_pipe_q <= '0;
      hit_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_sr[ROM_LAT-1:0];
      hit_pipe_q <= hit_sr[ROM_LAT-1:0];
    end
  end

  logic [PIX_W-1:0] pix_mux;
  assign pix_mux = hit_sr[ROM_LAT] ? bus.rom_q : '0;

  assign bus.upd_ready  = upd_ready;
  assign bus.rom_rd     = rom_rd_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.out_valid  = vld_sr[ROM_LAT];
  assign bus.glyph_hit  = hit_sr[ROM_LAT];
  assign bus.glyph_pix  = pix_mux;
  assign bus.err_sticky = err_q;

endmodule
